vga_frame_reader: RTL and testbench

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader_pkg.sv | 50 +++++
 rtl/vga_timing.sv | 63 ++++++
 rtl/vga_frame_reader.sv | 121 ++++++++++++
 tb/tb_vga_frame_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// vga_frame_reader_pkg
// Shared 640x480@60 Hz timing constants, the 160x120 source frame geometry,
// counter types and the per-pixel sync/visible flag bundle that is carried
// down the output pipeline.
// -----------------------------------------------------------------------------
package vga_frame_reader_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int H_VISIBLE    = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800
    localparam int H_SYNC_START = H_VISIBLE + H_FP;                   // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;              // 752, exclusive

    // Vertical timing, in lines.
    localparam int V_VISIBLE    = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525
    localparam int V_SYNC_START = V_VISIBLE + V_FP;                   // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;              // 492, exclusive

    // Source frame buffer: each stored pixel covers a 4x4 block on screen.
    localparam int SRC_W       = 160;
    localparam int SRC_H       = 120;
    localparam int NPIXELS     = SRC_W * SRC_H;                       // 19200
    localparam int SCALE_SHIFT = 2;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Sync levels are carried already in their active-low output polarity.
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic visible;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, visible: 1'b0};

    // True when lo <= val < hi_excl.
    function automatic logic in_range(input cnt_t val, input int lo, input int hi_excl);
        return (val >= cnt_t'(lo)) && (val < cnt_t'(hi_excl));
    endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Free-running 800x525 raster counters and the raw (undelayed) sync and
// visible flags for the current counter position.
//
// Ports
//   pclk       in   pixel clock, rising edge
//   rst        in   asynchronous active-low reset
//   h_cnt      out  horizontal position 0..799
//   v_cnt      out  vertical position 0..524
//   line_end   out  h_cnt is 799 (next edge wraps h and steps v)
//   frame_end  out  last pixel of the frame (h=799, v=524)
//   flags      out  raw hsync_n / vsync_n / visible for (h_cnt, v_cnt)
// -----------------------------------------------------------------------------
module vga_timing
    import vga_frame_reader_pkg::*;
(
    input  logic       pclk,
    input  logic       rst,
    output cnt_t       h_cnt,
    output cnt_t       v_cnt,
    output logic       line_end,
    output logic       frame_end,
    output vga_flags_t flags
);

    cnt_t h_q, h_d;
    cnt_t v_q, v_d;

    // NOTE: every signal written in this block is given a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        line_end  = (h_q == cnt_t'(H_TOTAL - 1));
        frame_end = line_end && (v_q == cnt_t'(V_TOTAL - 1));

        h_d = h_q + cnt_t'(1);
        v_d = v_q;
        if (line_end) begin
            h_d = '0;
            v_d = frame_end ? '0 : v_q + cnt_t'(1);
        end

        flags.hsync_n = !in_range(h_q, H_SYNC_START, H_SYNC_END);
        flags.vsync_n = !in_range(v_q, V_SYNC_START, V_SYNC_END);
        flags.visible = (h_q < cnt_t'(H_VISIBLE)) && (v_q < cnt_t'(V_VISIBLE));
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt = h_q;
    assign v_cnt = v_q;

endmodule

// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
// Scans a 160x120 RGB111 frame buffer and displays it 4x upscaled on a
// 640x480@60 Hz VGA raster. The read address is built from a per-row base
// that steps by one source row every fourth visible line, so no multiplier
// is needed. Sync and visible flags travel through two register stages so
// they leave the block aligned with the pixel returned by the synchronous
// frame-buffer read.
//
// Ports
//   pclk         in   25 MHz pixel clock, rising edge
//   rst          in   asynchronous active-low reset
//   mem_px_addr  out  registered frame-buffer read address, 0..19199
//   mem_px_data  in   frame-buffer data, valid one pclk after mem_px_addr
//   vga_hsync    out  horizontal sync, active-low
//   vga_vsync    out  vertical sync, active-low
//   vga_r/g/b    out  RGB444 colour, forced to 0 outside the visible area
//   frame_start  out  one-pclk pulse after the counters pass h=0, v=0
// -----------------------------------------------------------------------------
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int AW = 15,
    parameter int DW = 3
) (
    input  logic          pclk,
    input  logic          rst,
    output logic [AW-1:0] mem_px_addr,
    input  logic [DW-1:0] mem_px_data,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          frame_start
);

    cnt_t       h_cnt;
    cnt_t       v_cnt;
    logic       line_end;
    logic       frame_end;
    vga_flags_t flags_raw;

    vga_timing u_timing (
        .pclk      (pclk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .frame_end (frame_end),
        .flags     (flags_raw)
    );

    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] addr_q, addr_d;
    vga_flags_t    flags_s1_q, flags_s1_d;
    vga_flags_t    flags_s2_q, flags_s2_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        // row_base always equals (v>>2)*160 for the current visible line.
        // v_cnt[1:0]==3 with v<479 means the line about to start is a
        // multiple of 4 inside the visible area, i.e. a new source row.
        row_base_d = row_base_q;
        if (frame_end) begin
            row_base_d = '0;
        end else if (line_end && (v_cnt[1:0] == 2'b11) && (v_cnt < cnt_t'(V_VISIBLE - 1))) begin
            row_base_d = row_base_q + AW'(SRC_W);
        end

        // Outside the visible area the address parks on its last value, so
        // the frame buffer is never asked for anything beyond pixel 19199.
        addr_d = addr_q;
        if (flags_raw.visible) begin
            addr_d = row_base_q + AW'(h_cnt >> SCALE_SHIFT);
        end

        // Stage 1 lines up with the address register, stage 2 with the
        // frame buffer's read register.
        flags_s1_d = flags_raw;
        flags_s2_d = flags_s1_q;

        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            row_base_q    <= '0;
            addr_q        <= '0;
            flags_s1_q    <= FLAGS_IDLE;
            flags_s2_q    <= FLAGS_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            flags_s1_q    <= flags_s1_d;
            flags_s2_q    <= flags_s2_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_px_addr = addr_q;
    assign vga_hsync   = flags_s2_q.hsync_n;
    assign vga_vsync   = flags_s2_q.vsync_n;
    assign frame_start = frame_start_q;

    // mem_px_data comes straight from the frame buffer's read register, so
    // the colour is the registered pixel gated by the registered visible
    // flag; both change on the same edge, two pclk after the counters.
    always_comb begin
        vga_r = 4'h0;
        vga_g = 4'h0;
        vga_b = 4'h0;
        if (flags_s2_q.visible) begin
            vga_r = {4{mem_px_data[2]}};
            vga_g = {4{mem_px_data[1]}};
            vga_b = {4{mem_px_data[0]}};
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_reader
// Directed bench for vga_frame_reader. A reference raster position (pos =
// v*800 + h of the DUT counters) is stepped alongside the DUT; the expected
// address, sync levels, colour and frame_start for every sampled cycle are
// computed from it with plain arithmetic. Long stretches of the frame are
// skipped by loading the vertical counter and row base once, so the run
// stays around 51k clocks. A synchronous frame-buffer model returns either
// addr[2:0] or a constant 3'b111.
// -----------------------------------------------------------------------------
module tb_vga_frame_reader;

    localparam int FRAME = 420000;

    logic        pclk = 1'b0;
    logic        rst  = 1'b0;
    logic [14:0] mem_px_addr;
    logic [2:0]  mem_px_data = 3'b000;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    logic        mem_ones = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;
    int pos   = 0;   // DUT counter position during the current cycle
    int since = 0;   // clock edges since reset release (saturating)
    int cyc   = 0;

    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int   hs_fall_prev = 0;
    int   hs_fall_last = 0;
    int   hs_low       = 0;
    int   vs_fall_last = 0;
    int   vs_low       = 0;
    int   fs_count     = 0;

    vga_frame_reader #(.AW(15), .DW(3)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #20 pclk = ~pclk;

    // Synchronous-read frame buffer.
    always @(posedge pclk) mem_px_data <= mem_ones ? 3'b111 : mem_px_addr[2:0];

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (pos h=%0d v=%0d)", tag, got, exp, pos % 800, pos / 800);
        end
    endtask

    // Source address the DUT should hold for counter position p.
    function automatic int src_addr(input int p);
        int h;
        int v;
        h = p % 800;
        v = p / 800;
        if (v >= 480) return 19199;
        if (h >= 640) h = 639;
        return (v / 4) * 160 + h / 4;
    endfunction

    // {hsync_n, vsync_n, visible} for counter position p.
    function automatic logic [2:0] raw_flags(input int p);
        int h;
        int v;
        h = p % 800;
        v = p / 800;
        return {!(h >= 656 && h < 752), !(v >= 490 && v < 492), (h < 640 && v < 480)};
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
        if (rst) begin
            pos = (pos + 1) % FRAME;
            if (since < 16) since++;
        end
    endtask

    task automatic track();
        if (prev_hs && !vga_hsync) begin
            hs_fall_prev = hs_fall_last;
            hs_fall_last = cyc;
        end
        if (!prev_hs && vga_hsync) hs_low = cyc - hs_fall_last;
        if (prev_vs && !vga_vsync) vs_fall_last = cyc;
        if (!prev_vs && vga_vsync) vs_low = cyc - vs_fall_last;
        if (frame_start) fs_count++;
        prev_hs = vga_hsync;
        prev_vs = vga_vsync;
    endtask

    task automatic check_cycle();
        int         p1;
        int         p2;
        int         e_addr;
        logic [2:0] f;
        logic [2:0] d;
        logic [11:0] e_rgb;
        p1     = (pos + FRAME - 1) % FRAME;
        p2     = (pos + FRAME - 2) % FRAME;
        e_addr = (since == 0) ? 0 : src_addr(p1);
        f      = (since < 2) ? 3'b110 : raw_flags(p2);
        d      = mem_ones ? 3'b111 : 3'(src_addr(p2));
        e_rgb  = f[0] ? {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}} : 12'h000;
        check("addr",   mem_px_addr, e_addr);
        check("hsync",  vga_hsync, f[2]);
        check("vsync",  vga_vsync, f[1]);
        check("rgb",    {vga_r, vga_g, vga_b}, e_rgb);
        check("fstart", frame_start, (since >= 1) && (pos == 1));
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (pos != target && n < 60000) begin
            tick();
            track();
            check_cycle();
            n++;
        end
        if (pos != target) check("run_to_timeout", pos, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  mem_px_addr, 0);
        check({tag, "_hsync"}, vga_hsync, 1);
        check({tag, "_vsync"}, vga_vsync, 1);
        check({tag, "_rgb"},   {vga_r, vga_g, vga_b}, 12'h000);
        check({tag, "_fs"},    frame_start, 0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check_reset_outputs("rst");
        @(negedge pclk);
        rst = 1'b1;
        check_cycle();

        // ---------------- first lines, addr[2:0] memory ----------------
        run_to(1);
        check("fs_first", frame_start, 1);
        check("addr_h0", mem_px_addr, 0);
        run_to(5);
        check("addr_h4", mem_px_addr, 1);
        run_to(6);
        check("rgb_h4", {vga_r, vga_g, vga_b}, 12'h00F);
        run_to(1700);
        check("hs_period", hs_fall_last - hs_fall_prev, 800);
        check("hs_low", hs_low, 96);
        run_to(4 * 800 + 1);
        check("rb_v4", mem_px_addr, 160);
        run_to(8 * 800 + 1);
        check("rb_v8", mem_px_addr, 320);
        run_to(8 * 800 + 100);

        // ---------------- jump to v=475, constant white memory ----------------
        mem_ones = 1'b1;
        force dut.u_timing.v_q = 10'd475;
        force dut.row_base_q   = 15'd18880;
        pos = 475 * 800 + 100;
        tick();
        release dut.u_timing.v_q;
        release dut.row_base_q;
        repeat (3) tick();

        run_to(476 * 800 + 1);
        check("rb_v476", mem_px_addr, 19040);
        run_to(479 * 800 + 640);
        check("addr_last", mem_px_addr, 19199);
        run_to(479 * 800 + 641);
        check("rgb_last", {vga_r, vga_g, vga_b}, 12'hFFF);
        run_to(479 * 800 + 642);
        check("rgb_hblank", {vga_r, vga_g, vga_b}, 12'h000);
        run_to(481 * 800 + 300);
        check("addr_vblank", mem_px_addr, 19199);
        check("rgb_vblank", {vga_r, vga_g, vga_b}, 12'h000);
        run_to(493 * 800);
        check("vs_low", vs_low, 1600);
        fs_count = 0;
        run_to(1);
        check("fs_frame2", frame_start, 1);
        check("rb_wrap", mem_px_addr, 0);
        run_to(900);
        check("fs_count_frame", fs_count, 1);

        // ---------------- reset mid-frame at h=300, v=200 ----------------
        mem_ones = 1'b0;
        run_to(1 * 800 + 100);
        force dut.u_timing.v_q = 10'd200;
        force dut.row_base_q   = 15'd8000;
        pos = 200 * 800 + 100;
        tick();
        release dut.u_timing.v_q;
        release dut.row_base_q;
        repeat (3) tick();
        run_to(200 * 800 + 300);
        check("addr_pre_rst", mem_px_addr, 8074);
        #5;
        rst   = 1'b0;
        pos   = 0;
        since = 0;
        #1;
        check_reset_outputs("async");
        repeat (3) begin
            tick();
            check_reset_outputs("hold");
        end
        @(negedge pclk);
        rst      = 1'b1;
        fs_count = 0;
        prev_hs  = 1'b1;
        prev_vs  = 1'b1;
        check_cycle();
        run_to(1);
        check("fs_restart", frame_start, 1);
        check("addr_restart", mem_px_addr, 0);
        run_to(4 * 800 + 1);
        check("rb_v4_restart", mem_px_addr, 160);
        check("fs_once", fs_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
